// File: rtl/attn_score_scaler.sv
// Attention-score scaling stage: per-tile runtime right shift with fractional
// realignment, optional round-half-up, signed saturation and a 2-stage elastic pipe.
module attn_score_scaler #(
    parameter int WIDTH_IN       = 32,
    parameter int FRAC_WIDTH_IN  = 16,
    parameter int WIDTH_OUT      = 16,
    parameter int FRAC_WIDTH_OUT = 8,
    parameter int NUM_LANES      = 16,
    parameter int SHIFT_W        = 4,
    parameter int TILE_BEATS     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [SHIFT_W-1:0]             shamt,
    input  logic                           round_mode,
    input  logic                           clear_flags,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_LANES*WIDTH_IN-1:0]  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_LANES*WIDTH_OUT-1:0] out_data,
    output logic                           out_last,
    output logic                           sat_sticky
);

    localparam int D     = FRAC_WIDTH_IN - FRAC_WIDTH_OUT;
    localparam int CNT_W = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;
    localparam int SW    = WIDTH_IN + 1;
    localparam logic [WIDTH_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    logic [CNT_W-1:0]              beat_cnt_r;
    logic [SHIFT_W-1:0]            cfg_shamt_r;
    logic                          cfg_round_r;
    logic                          s1_valid_r;
    logic                          s1_last_r;
    logic [NUM_LANES*SW-1:0]       s1_data_r;
    logic                          s2_valid_r;
    logic [NUM_LANES*WIDTH_OUT-1:0] out_data_r;
    logic                          out_last_r;
    logic                          sat_sticky_r;

    logic                          s1_moves_s;
    logic                          in_ready_s;
    logic                          accept_s;
    logic                          s2_load_s;
    logic                          first_beat_s;
    logic                          last_tag_s;
    logic [SHIFT_W-1:0]            eff_shamt_s;
    logic                          eff_round_s;
    logic [NUM_LANES*SW-1:0]       scaled_s;
    logic [NUM_LANES*WIDTH_OUT-1:0] sat_data_s;
    logic                          any_sat_s;

    // The add is done one bit wider than the input so the rounding bias never overflows.
    function automatic logic signed [SW-1:0] scale_lane(input logic [WIDTH_IN-1:0] x,
                                                        input logic [SHIFT_W-1:0] sh,
                                                        input logic rnd);
        logic signed [SW-1:0] ext;
        logic signed [SW-1:0] bias;
        int s;
        ext  = signed'({x[WIDTH_IN-1], x});
        bias = {SW{1'b0}};
        s    = int'(sh) + D;
        if (s >= SW) begin
            scale_lane = (rnd || !x[WIDTH_IN-1]) ? {SW{1'b0}} : {SW{1'b1}};
        end else if (rnd && (s > 32'sd0)) begin
            bias       = {{(SW-1){1'b0}}, 1'b1} << (s - 32'sd1);
            scale_lane = (ext + bias) >>> s;
        end else begin
            scale_lane = ext >>> s;
        end
    endfunction

    function automatic logic sat_hit(input logic [SW-1:0] y);
        sat_hit = !((&y[SW-1:WIDTH_OUT-1]) || !(|y[SW-1:WIDTH_OUT-1]));
    endfunction

    function automatic logic [WIDTH_OUT-1:0] sat_val(input logic [SW-1:0] y);
        if (sat_hit(y)) begin
            sat_val = y[SW-1] ? OUT_MIN : OUT_MAX;
        end else begin
            sat_val = y[WIDTH_OUT-1:0];
        end
    endfunction

    assign s1_moves_s   = !s2_valid_r || out_ready;
    assign in_ready_s   = rst_n && (!s1_valid_r || s1_moves_s);
    assign accept_s     = in_valid && in_ready_s;
    assign s2_load_s    = s1_valid_r && s1_moves_s;
    assign first_beat_s = (beat_cnt_r == {CNT_W{1'b0}});
    assign last_tag_s   = (beat_cnt_r == CNT_W'(TILE_BEATS - 1));

    assign in_ready   = in_ready_s;
    assign out_valid  = s2_valid_r;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign sat_sticky = sat_sticky_r;

    // The first beat of a tile uses the live config; later beats use the latched copy.
    always_comb begin
        eff_shamt_s = cfg_shamt_r;
        eff_round_s = cfg_round_r;
        if (first_beat_s) begin
            eff_shamt_s = shamt;
            eff_round_s = round_mode;
        end else begin
            eff_shamt_s = cfg_shamt_r;
            eff_round_s = cfg_round_r;
        end
    end

    // Stage-1 datapath: per-lane shift/round of the incoming beat.
    always_comb begin
        scaled_s = {(NUM_LANES*SW){1'b0}};
        for (int k = 0; k < NUM_LANES; k++) begin
            scaled_s[k*SW +: SW] = scale_lane(in_data[k*WIDTH_IN +: WIDTH_IN], eff_shamt_s, eff_round_s);
        end
    end

    // Stage-2 datapath: per-lane clamp and the beat-level saturation flag.
    always_comb begin
        sat_data_s = {(NUM_LANES*WIDTH_OUT){1'b0}};
        any_sat_s  = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            sat_data_s[k*WIDTH_OUT +: WIDTH_OUT] = sat_val(s1_data_r[k*SW +: SW]);
            any_sat_s = any_sat_s | sat_hit(s1_data_r[k*SW +: SW]);
        end
    end

    // Tile beat counter and per-tile config latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r  <= {CNT_W{1'b0}};
            cfg_shamt_r <= {SHIFT_W{1'b0}};
            cfg_round_r <= 1'b0;
        end else if (accept_s) begin
            beat_cnt_r <= last_tag_s ? {CNT_W{1'b0}} : beat_cnt_r + CNT_W'(1);
            if (first_beat_s) begin
                cfg_shamt_r <= shamt;
                cfg_round_r <= round_mode;
            end
        end
    end

    // Stage-1 register: scaled lanes plus the last-beat tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_data_r  <= {(NUM_LANES*SW){1'b0}};
        end else if (accept_s) begin
            s1_valid_r <= 1'b1;
            s1_last_r  <= last_tag_s;
            s1_data_r  <= scaled_s;
        end else if (s1_moves_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage-2 output register and the sticky saturation flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            out_data_r   <= {(NUM_LANES*WIDTH_OUT){1'b0}};
            out_last_r   <= 1'b0;
            sat_sticky_r <= 1'b0;
        end else begin
            if (s2_load_s) begin
                s2_valid_r <= 1'b1;
                out_data_r <= sat_data_s;
                out_last_r <= s1_last_r;
            end else if (out_ready) begin
                s2_valid_r <= 1'b0;
            end
            if (s2_load_s && any_sat_s) begin
                sat_sticky_r <= 1'b1;
            end else if (clear_flags) begin
                sat_sticky_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_attn_score_scaler.sv
// Scoreboard bench for attn_score_scaler: expected beats are queued on acceptance
// from an independent 64-bit arithmetic model and compared as the DUT emits them.
module tb_attn_score_scaler;

    localparam int NL  = 16;
    localparam int WI  = 32;
    localparam int WO  = 16;
    localparam int FI  = 16;
    localparam int FO  = 8;
    localparam int SHW = 4;
    localparam int TB  = 4;
    localparam int IW  = NL*WI;
    localparam int OW  = NL*WO;
    localparam longint OMAX = (longint'(1) << (WO-1)) - 1;
    localparam longint OMIN = -(longint'(1) << (WO-1));

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [SHW-1:0] shamt = '0;
    logic           round_mode = 1'b0;
    logic           clear_flags = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [IW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [OW-1:0]  out_data;
    logic           out_last;
    logic           sat_sticky;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          l;
    } exp_t;

    exp_t           sbq[$];
    int             n_tests = 0;
    int             n_fail = 0;
    int             inflight = 0;
    int             tb_cnt = 0;
    logic [SHW-1:0] tb_sh = '0;
    logic           tb_rnd = 1'b0;
    logic           prev_stall = 1'b0;
    logic [OW-1:0]  prev_d = '0;
    logic           prev_l = 1'b0;
    bit             bp_mode = 1'b0;
    logic           out_ready_cmd = 1'b1;

    attn_score_scaler dut (
        .clk(clk), .rst_n(rst_n), .shamt(shamt), .round_mode(round_mode),
        .clear_flags(clear_flags), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .sat_sticky(sat_sticky)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] model(input logic [IW-1:0] din, input logic [SHW-1:0] sh, input logic rnd);
        logic [OW-1:0] r;
        int s;
        r = '0;
        s = int'(sh) + FI - FO;
        for (int k = 0; k < NL; k++) begin
            logic signed [WI-1:0] xs;
            longint x;
            longint y;
            xs = din[k*WI +: WI];
            x  = longint'(xs);
            if (rnd && s > 0) x = x + (longint'(1) << (s-1));
            y = x >>> s;
            if (y > OMAX) y = OMAX;
            else if (y < OMIN) y = OMIN;
            r[k*WO +: WO] = y[WO-1:0];
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] fill(input logic [WI-1:0] a, input logic [WI-1:0] b);
        logic [IW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*WI +: WI] = (k % 2 == 0) ? a : b;
        return r;
    endfunction

    function automatic logic [IW-1:0] small_beat();
        logic [IW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*WI +: WI] = $urandom_range(0, 32'h007F_FFFF) - 32'h0040_0000;
        return r;
    endfunction

    function automatic logic [IW-1:0] wild_beat();
        logic [IW-1:0] r;
        for (int k = 0; k < NL; k++) r[k*WI +: WI] = $urandom;
        return r;
    endfunction

    task automatic monitor_step();
        exp_t e;
        logic acc;
        logic pop;
        if (!rst_n) begin
            sbq.delete();
            inflight = 0;
            tb_cnt = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", OW'(out_valid), OW'(1'b1));
                check_eq("stall_data", out_data, prev_d);
                check_eq("stall_last", OW'(out_last), OW'(prev_l));
            end
            check_eq("in_ready", OW'(in_ready), OW'(!(inflight == 2 && !out_ready)));
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                if (sbq.size() == 0) begin
                    check_eq("sb_unexpected", OW'(out_valid), OW'(1'b0));
                end else begin
                    e = sbq.pop_front();
                    check_eq("data", out_data, e.d);
                    check_eq("last", OW'(out_last), OW'(e.l));
                end
            end
            if (acc) begin
                if (tb_cnt == 0) begin
                    tb_sh  = shamt;
                    tb_rnd = round_mode;
                end
                e.d = model(in_data, tb_sh, tb_rnd);
                e.l = (tb_cnt == TB-1);
                sbq.push_back(e);
                tb_cnt = (tb_cnt == TB-1) ? 0 : tb_cnt + 1;
            end
            inflight = inflight + int'(acc) - int'(pop);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_l = out_last;
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic [SHW-1:0] sh, input logic rnd);
        logic ok;
        int guard;
        in_valid = 1'b1;
        in_data = d;
        shamt = sh;
        round_mode = rnd;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) check_eq("send_timeout", OW'(ok), OW'(1'b1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        in_valid = 1'b0;
        while (sbq.size() != 0 && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check_eq("drain", OW'(sbq.size()), OW'(0));
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            forever begin
                @(posedge clk);
                #1;
                out_ready = bp_mode ? 1'($urandom_range(0, 1)) : out_ready_cmd;
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_out_valid", OW'(out_valid), OW'(1'b0));
        check_eq("rst_in_ready", OW'(in_ready), OW'(1'b0));
        check_eq("rst_out_data", out_data, OW'(0));
        check_eq("rst_out_last", OW'(out_last), OW'(1'b0));
        check_eq("rst_sat", OW'(sat_sticky), OW'(1'b0));
        rst_n = 1'b1;
        #1;
        check_eq("ready_after_rst", OW'(in_ready), OW'(1'b1));

        // tile A: basic scale, truncate rounding corner, latency
        send_beat(fill(32'h0001_0000, 32'h0001_0000), 4'd4, 1'b0);
        in_valid = 1'b0;
        check_eq("lat_edge1", OW'(out_valid), OW'(1'b0));
        @(posedge clk);
        #1;
        check_eq("lat_edge2", OW'(out_valid), OW'(1'b1));
        check_eq("basic_lane", OW'(out_data[WO-1:0]), OW'(16'h0010));
        send_beat(fill(32'h0000_0800, 32'hFFFF_F800), 4'd4, 1'b0);
        send_beat(small_beat(), 4'd4, 1'b0);
        send_beat(small_beat(), 4'd4, 1'b0);
        drain();
        check_eq("sat_after_A", OW'(sat_sticky), OW'(1'b0));

        // tile B: round-half-up
        send_beat(fill(32'h0000_0800, 32'hFFFF_F800), 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(small_beat(), 4'd4, 1'b1);
        drain();
        check_eq("sat_after_B", OW'(sat_sticky), OW'(1'b0));

        // tile C: saturation, then a plain clear
        send_beat(fill(32'h7FFF_FFFF, 32'h8000_0000), 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(small_beat(), 4'd0, 1'b0);
        drain();
        check_eq("sat_set", OW'(sat_sticky), OW'(1'b1));
        clear_flags = 1'b1;
        @(posedge clk);
        #1;
        clear_flags = 1'b0;
        check_eq("sat_cleared", OW'(sat_sticky), OW'(1'b0));

        // tile D: clear coincident with a saturating beat entering stage 2
        send_beat(fill(32'h8000_0000, 32'h7FFF_FFFF), 4'd0, 1'b0);
        clear_flags = 1'b1;
        send_beat(small_beat(), 4'd0, 1'b0);
        clear_flags = 1'b0;
        send_beat(small_beat(), 4'd0, 1'b0);
        send_beat(small_beat(), 4'd0, 1'b0);
        drain();
        check_eq("sat_set_wins", OW'(sat_sticky), OW'(1'b1));

        // tiles E/F: shamt changes mid-tile, sampled only at tile start
        for (int i = 0; i < 8; i++)
            send_beat((i % 2 == 0) ? fill(32'h0001_0000, 32'hFFFF_0000) : small_beat(), (i < 2) ? 4'd4 : 4'd2, 1'b0);
        drain();

        // backpressure with random out_ready and random config
        bp_mode = 1'b1;
        for (int i = 0; i < 10; i++) send_beat(wild_beat(), SHW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        drain();
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // finish the partial tile, then hold two beats of a new tile and reset
        send_beat(small_beat(), 4'd3, 1'b0);
        send_beat(small_beat(), 4'd3, 1'b0);
        drain();
        out_ready_cmd = 1'b0;
        @(posedge clk);
        #2;
        send_beat(small_beat(), 4'd3, 1'b0);
        send_beat(small_beat(), 4'd3, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("held_ready", OW'(in_ready), OW'(1'b0));
        check_eq("sat_pre_rst", OW'(sat_sticky), OW'(1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", OW'(out_valid), OW'(1'b0));
        check_eq("mid_rst_sat", OW'(sat_sticky), OW'(1'b0));
        check_eq("mid_rst_last", OW'(out_last), OW'(1'b0));
        check_eq("mid_rst_ready", OW'(in_ready), OW'(1'b0));
        out_ready_cmd = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) send_beat(small_beat(), 4'd1, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
